// File: rtl/sd_fifo_head_mc.sv
`default_nettype none
// ============================================================================
// Module  : sd_fifo_head_mc
// Purpose : Multi-channel FIFO write heads sharing one memory write port,
//           round-robin arbitrated, with optional commit/abort per channel.
// Rev     : 1.0  initial release
// ============================================================================
module sd_fifo_head_mc #(
  parameter int channels  = 4,
  parameter int depth     = 64,
  parameter int commit    = 0,
  parameter int afull_lvl = 8,
  localparam int asz = $clog2(depth),
  localparam int csz = (channels > 1) ? $clog2(channels) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [channels-1:0]     c_srdy,
  output logic [channels-1:0]     c_drdy,
  input  logic [channels-1:0]     c_commit,
  input  logic [channels-1:0]     c_abort,
  input  logic [channels*asz-1:0] bound_low,
  input  logic [channels*asz-1:0] bound_high,
  input  logic [channels*asz-1:0] rdptr,
  output logic [channels*asz-1:0] cur_wrptr,
  output logic [channels*asz-1:0] com_wrptr,
  output logic                    mem_we,
  output logic [asz-1:0]          mem_addr,
  output logic [csz-1:0]          mem_ch,
  output logic [channels-1:0]     c_afull
);

  logic [asz-1:0]      w_cur [channels];
  logic [channels-1:0] w_elig;
  logic [csz-1:0]      r_rr;
  logic [csz-1:0]      w_gnt;
  logic [csz-1:0]      w_cand;
  logic [csz:0]        w_sum;
  logic                w_found;
  logic                w_any;

  generate
    for (genvar i = 0; i < channels; i++) begin : g_ch
      logic [asz-1:0] w_low, w_high, w_rd, w_p1;
      logic [asz-1:0] r_cur_q;
      logic [asz:0]   w_occ;
      logic           w_full, w_gnt_i, r_afull_q;

      assign w_low  = bound_low[i*asz +: asz];
      assign w_high = bound_high[i*asz +: asz];
      assign w_rd   = rdptr[i*asz +: asz];
      assign w_p1   = (r_cur_q == w_high) ? w_low : r_cur_q + 1'b1;
      assign w_full = (w_p1 == w_rd);
      assign w_elig[i] = enable & c_srdy[i] & ~w_full & ~((commit != 0) & c_abort[i]);
      assign w_gnt_i   = w_any & (w_gnt == csz'(i));

      // Occupancy wraps within the channel's own region, not the whole memory.
      assign w_occ = (r_cur_q >= w_rd)
                   ? ({1'b0, r_cur_q} - {1'b0, w_rd})
                   : (({1'b0, w_high} - {1'b0, w_low} + 1'b1) - ({1'b0, w_rd} - {1'b0, r_cur_q}));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_afull_q <= 1'b0;
        else       r_afull_q <= (w_occ >= (asz+1)'(afull_lvl));
      end

      assign c_afull[i]               = r_afull_q;
      assign w_cur[i]                 = r_cur_q;
      assign cur_wrptr[i*asz +: asz]  = r_cur_q;

      if (commit != 0) begin : g_commit
        logic [asz-1:0] r_com_q;

        always_ff @(posedge clk or posedge reset) begin
          if (reset)                       r_com_q <= w_low;
          else if (w_gnt_i & c_commit[i])  r_com_q <= w_p1;
        end

        always_ff @(posedge clk or posedge reset) begin
          if (reset)             r_cur_q <= w_low;
          else if (c_abort[i])   r_cur_q <= r_com_q;
          else if (w_gnt_i)      r_cur_q <= w_p1;
        end

        assign com_wrptr[i*asz +: asz] = r_com_q;
      end else begin : g_nocommit
        logic w_unused;
        assign w_unused = c_commit[i] ^ c_abort[i];

        always_ff @(posedge clk or posedge reset) begin
          if (reset)        r_cur_q <= w_low;
          else if (w_gnt_i) r_cur_q <= w_p1;
        end

        assign com_wrptr[i*asz +: asz] = r_cur_q;
      end
    end
  endgenerate

  // Round-robin search beginning at r_rr; first eligible channel wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < channels; k++) begin
      w_sum = {1'b0, r_rr} + (csz+1)'(k);
      if (w_sum >= (csz+1)'(channels)) w_sum = w_sum - (csz+1)'(channels);
      w_cand = w_sum[csz-1:0];
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_gnt   = w_cand;
      end
    end
  end

  assign w_any = w_found & ~reset;

  always_comb begin
    c_drdy   = '0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_ch   = '0;
    if (w_any) begin
      c_drdy[w_gnt] = 1'b1;
      mem_we        = 1'b1;
      mem_addr      = w_cur[w_gnt];
      mem_ch        = w_gnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_rr <= '0;
    else if (w_any) r_rr <= (w_gnt == csz'(channels-1)) ? '0 : w_gnt + 1'b1;
  end

endmodule
`default_nettype wire

// File: doc/sd_fifo_head_mc.md
SD_FIFO_HEAD_MC -- requirements
Module: sd_fifo_head_mc

Interface
REQ-001 SHALL have parameter channels, default 4, number of independent FIFO heads sharing one memory write port.
REQ-002 SHALL have parameter depth, default 64, words in shared memory.
REQ-003 SHALL have parameter commit, default 0, 1 enables write/commit/abort behaviour on every channel.
REQ-004 SHALL have parameter afull_lvl, default 8, almost-full occupancy threshold in words.
REQ-005 SHALL have derived parameters asz=$clog2(depth) and csz=max(1,$clog2(channels)).
REQ-006 SHALL have ports, in order:
- clk  in  1  sole clock, all state rising-edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  memory port available this cycle.
- c_srdy  in  channels  per-channel producer ready.
- c_drdy  out  channels  per-channel accept, at most one bit set.
- c_commit  in  channels  commit accompanying a write.
- c_abort  in  channels  rewind to last commit; asserted only with c_srdy low.
- bound_low  in  channels*asz  region start, channel i at bits [i*asz +: asz].
- bound_high  in  channels*asz  region end, inclusive, same packing.
- rdptr  in  channels*asz  tail read pointers, same packing.
- cur_wrptr  out  channels*asz  write pointers, same packing.
- com_wrptr  out  channels*asz  committed pointers to tails, same packing.
- mem_we  out  1  memory write strobe.
- mem_addr  out  asz  memory write address.
- mem_ch  out  csz  granted channel index, data-mux select.
- c_afull  out  channels  almost-full per channel.

Function
REQ-007 SHALL compute per channel wrptr_p1 = bound_low when cur_wrptr==bound_high, else cur_wrptr+1.
REQ-008 SHALL treat channel full when wrptr_p1==rdptr; at most region size minus 1 entries usable.
REQ-009 SHALL make channel eligible when c_srdy & !full & !(commit & c_abort), and grant only if enable high.
REQ-010 SHALL grant at most one eligible channel per cycle, round-robin, search starting at priority pointer rr.
REQ-011 SHALL, after a grant to channel g, register rr = g+1 wrapping to 0 after channels-1; rr unchanged without a grant.
REQ-012 SHALL drive c_drdy, mem_we, mem_addr = granted cur_wrptr, mem_ch = g combinationally in grant cycle; mem_we=0, c_drdy=0, mem_addr=0, mem_ch=0 without grant.
REQ-013 SHALL advance granted channel cur_wrptr to wrptr_p1 at the next edge; other channels hold.
REQ-014 SHALL, with commit=1, load com_wrptr into cur_wrptr at next edge on c_abort, regardless of grant to other channels.
REQ-015 SHALL, with commit=1, set com_wrptr to wrptr_p1 when granted with c_commit high; otherwise hold.
REQ-016 SHALL, with commit=0, drive com_wrptr equal to cur_wrptr and ignore c_commit/c_abort.
REQ-017 SHALL compute occupancy in asz+1 bits: cur_wrptr-rdptr if cur_wrptr>=rdptr, else (bound_high-bound_low+1)-(rdptr-cur_wrptr).
REQ-018 SHALL register c_afull = occupancy >= afull_lvl, updated every cycle.
REQ-019 SHALL keep channels independent; a full or aborting channel does not block others.
REQ-020 SHALL not write memory when no channel eligible, including enable low for all cycles.

Reset
REQ-021 SHALL on reset assertion immediately set each cur_wrptr and com_wrptr to that channel's bound_low, rr=0, c_afull=0.
REQ-022 SHALL force c_drdy=0 and mem_we=0 while reset high; reset mid-transfer discards uncommitted and committed pointer state.

Verification
REQ-023 Reset, depth=64, 4 channels, regions 0-15/16-31/32-47/48-63 -> cur_wrptr = 0,16,32,48; all c_drdy=0.
REQ-024 All c_srdy high, enable high, 8 cycles -> grants 0,1,2,3,0,1,2,3; mem_addr 0,16,32,48,1,17,33,49.
REQ-025 Channel 1 only, rdptr=16, 15 writes -> cur_wrptr=31, 16th cycle c_drdy[1]=0; c_afull[1]=1 from occupancy 8.
REQ-026 commit=1, channel 0 writes 5 with c_commit on 3rd, then c_abort -> cur_wrptr 5 then 3; com_wrptr=3.
REQ-027 Channel 2 bound_high=47, cur_wrptr=47, rdptr=40, write -> mem_addr=47, next cur_wrptr=32 (wrap).
REQ-028 enable low with c_srdy all high -> no c_drdy, mem_we=0, pointers and rr unchanged.
